// File: rtl/r5_stage_ctrl_if.sv
// Sample-stream handshake and frame-timing bundle for one radix-5 SDF stage controller.
// master = stream source / datapath side, slave = the controller.
interface r5_stage_ctrl_if #(
   parameter int IDX_W = 5,
   parameter int TW_AW = 7
);
   logic             in_valid;
   logic             in_sof;
   logic [2:0]       ph;
   logic [IDX_W-1:0] idx;
   logic             buf_load;
   logic             bf_fire;
   logic             out_valid;
   logic             out_sof;
   logic             out_eof;
   logic [2:0]       out_ph;
   logic [IDX_W-1:0] out_idx;
   logic [TW_AW-1:0] tw_addr;
   logic             busy;
   logic             sync_err;

   modport master (
      output in_valid, in_sof,
      input  ph, idx, buf_load, bf_fire, out_valid, out_sof, out_eof,
      input  out_ph, out_idx, tw_addr, busy, sync_err
   );

   modport slave (
      input  in_valid, in_sof,
      output ph, idx, buf_load, bf_fire, out_valid, out_sof, out_eof,
      output out_ph, out_idx, tw_addr, busy, sync_err
   );
endinterface

// File: rtl/r5_stage_ctrl.sv
// Radix-5 SDF stage sequencer: input frame counting, delayed output framing, twiddle address.
// Outputs registered; output run starts LAT cycles after the first phase-4 sample, no backpressure.
module r5_stage_ctrl #(
   parameter int D     = 17,
   parameter int LAT   = 17,
   parameter int IDX_W = 5,
   parameter int TW_AW = 7
) (
   input  logic          clk,
   input  logic          rst_n,
   r5_stage_ctrl_if.slave bus
);
   localparam int               CNT_W    = (5 * D > 1) ? $clog2(5 * D) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(D - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [CNT_W-1:0] ARM_LOAD = CNT_W'(LAT - 1);

   typedef enum logic {IN_IDLE, IN_RUN} in_st_t;
   typedef enum logic {OUT_IDLE, OUT_RUN} out_st_t;

   in_st_t           r_in_st, w_in_st_nxt;
   out_st_t          r_out_st, w_out_st_nxt;
   logic [2:0]       r_ph, w_ph_nxt, r_out_ph, w_out_ph_nxt;
   logic [IDX_W-1:0] r_idx, w_idx_nxt, r_out_idx, w_out_idx_nxt;
   logic [CNT_W-1:0] r_arm_cnt, w_arm_cnt_nxt;
   logic             r_arm, w_arm_nxt;
   logic             r_buf_load, r_bf_fire, r_sync_err;
   logic             r_out_sof, r_out_eof, r_busy;
   logic [TW_AW-1:0] r_tw, w_tw;
   logic [IDX_W+2:0] w_prod;
   logic             w_err, w_cancel, w_arm_set, w_start;
   logic             w_in_last, w_out_last;

   assign w_in_last  = (r_ph == 3'd4) && (r_idx == IDX_LAST);
   assign w_out_last = (r_out_ph == 3'd4) && (r_out_idx == IDX_LAST);

   always_comb begin
      w_in_st_nxt = r_in_st;
      w_ph_nxt    = r_ph;
      w_idx_nxt   = r_idx;
      w_err       = 1'b0;
      w_cancel    = 1'b0;
      w_arm_set   = 1'b0;
      case (r_in_st)
         IN_IDLE: begin
            if (bus.in_valid && bus.in_sof) begin
               w_in_st_nxt = IN_RUN;
               w_ph_nxt    = 3'd0;
               w_idx_nxt   = '0;
            end
         end
         IN_RUN: begin
            if (w_in_last) begin
               // Frame complete: only a fresh sof may follow without a gap
               w_ph_nxt  = 3'd0;
               w_idx_nxt = '0;
               if (!(bus.in_valid && bus.in_sof)) begin
                  w_in_st_nxt = IN_IDLE;
                  w_err       = bus.in_valid;
               end
            end else if (!bus.in_valid) begin
               w_in_st_nxt = IN_IDLE;
               w_ph_nxt    = 3'd0;
               w_idx_nxt   = '0;
               w_err       = 1'b1;
               w_cancel    = 1'b1;
            end else if (bus.in_sof) begin
               w_ph_nxt  = 3'd0;
               w_idx_nxt = '0;
               w_err     = 1'b1;
               w_cancel  = 1'b1;
            end else if (r_idx == IDX_LAST) begin
               w_ph_nxt  = r_ph + 3'd1;
               w_idx_nxt = '0;
               w_arm_set = (r_ph == 3'd3);
            end else begin
               w_idx_nxt = r_idx + IDX_ONE;
            end
         end
         default: w_in_st_nxt = IN_IDLE;
      endcase
   end

   always_comb begin
      w_arm_nxt     = r_arm;
      w_arm_cnt_nxt = r_arm_cnt;
      w_start       = 1'b0;
      w_out_st_nxt  = r_out_st;
      w_out_ph_nxt  = r_out_ph;
      w_out_idx_nxt = r_out_idx;
      if (w_arm_set) begin
         w_arm_nxt     = 1'b1;
         w_arm_cnt_nxt = ARM_LOAD;
      end else if (r_arm) begin
         if (w_cancel) begin
            w_arm_nxt = 1'b0;
         end else if (r_arm_cnt == '0) begin
            w_arm_nxt = 1'b0;
            w_start   = 1'b1;
         end else begin
            w_arm_cnt_nxt = r_arm_cnt - CNT_W'(1);
         end
      end
      // A start landing on the last sample of a run chains straight into the next run
      if (w_start) begin
         w_out_st_nxt  = OUT_RUN;
         w_out_ph_nxt  = 3'd0;
         w_out_idx_nxt = '0;
      end else if (r_out_st == OUT_RUN) begin
         if (w_out_last) begin
            w_out_st_nxt  = OUT_IDLE;
            w_out_ph_nxt  = 3'd0;
            w_out_idx_nxt = '0;
         end else if (r_out_idx == IDX_LAST) begin
            w_out_ph_nxt  = r_out_ph + 3'd1;
            w_out_idx_nxt = '0;
         end else begin
            w_out_idx_nxt = r_out_idx + IDX_ONE;
         end
      end
   end

   assign w_prod = {{IDX_W{1'b0}}, w_out_ph_nxt} * {3'b000, w_out_idx_nxt};
   assign w_tw   = (w_out_st_nxt == OUT_RUN) ? TW_AW'(w_prod) : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_in_st    <= IN_IDLE;
         r_out_st   <= OUT_IDLE;
         r_ph       <= '0;
         r_idx      <= '0;
         r_out_ph   <= '0;
         r_out_idx  <= '0;
         r_arm      <= 1'b0;
         r_arm_cnt  <= '0;
         r_buf_load <= 1'b0;
         r_bf_fire  <= 1'b0;
         r_sync_err <= 1'b0;
         r_out_sof  <= 1'b0;
         r_out_eof  <= 1'b0;
         r_tw       <= '0;
         r_busy     <= 1'b0;
      end else begin
         r_in_st    <= w_in_st_nxt;
         r_out_st   <= w_out_st_nxt;
         r_ph       <= w_ph_nxt;
         r_idx      <= w_idx_nxt;
         r_out_ph   <= w_out_ph_nxt;
         r_out_idx  <= w_out_idx_nxt;
         r_arm      <= w_arm_nxt;
         r_arm_cnt  <= w_arm_cnt_nxt;
         r_buf_load <= (w_in_st_nxt == IN_RUN) && (w_ph_nxt != 3'd4);
         r_bf_fire  <= (w_in_st_nxt == IN_RUN) && (w_ph_nxt == 3'd4);
         r_sync_err <= w_err;
         r_out_sof  <= w_start;
         r_out_eof  <= (w_out_st_nxt == OUT_RUN) && (w_out_ph_nxt == 3'd4)
                       && (w_out_idx_nxt == IDX_LAST);
         r_tw       <= w_tw;
         r_busy     <= (w_in_st_nxt == IN_RUN) || w_arm_nxt || (w_out_st_nxt == OUT_RUN);
      end
   end

   assign bus.ph        = r_ph;
   assign bus.idx       = r_idx;
   assign bus.buf_load  = r_buf_load;
   assign bus.bf_fire   = r_bf_fire;
   assign bus.sync_err  = r_sync_err;
   assign bus.out_valid = (r_out_st == OUT_RUN);
   assign bus.out_sof   = r_out_sof;
   assign bus.out_eof   = r_out_eof;
   assign bus.out_ph    = r_out_ph;
   assign bus.out_idx   = r_out_idx;
   assign bus.tw_addr   = r_tw;
   assign bus.busy      = r_busy;
endmodule

// File: tb/tb_r5_stage_ctrl.sv
// Bench for r5_stage_ctrl: directed frame scenarios with a checkpoint table, plus a random
// stream, all compared every cycle against a frame-position reference model.
module tb_r5_stage_ctrl;
   localparam int D     = 17;
   localparam int LAT   = 17;
   localparam int IDX_W = 5;
   localparam int TW_AW = 7;
   localparam int FL    = 5 * D;

   localparam int F_BL = 0, F_BF = 1, F_OV = 2, F_OS = 3, F_OE = 4, F_TW = 5;
   localparam int F_BUSY = 6, F_ERR = 7, F_OPH = 8, F_OIDX = 9, F_PH = 10, F_IDX = 11;

   typedef struct {
      int sc;
      int cyc;
      int sel;
      int exp;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   vec_t vecs[$];

   // reference model state: positions inside the frame, -1 when absent
   int   m_pos, m_arm_at, m_opos;
   bit   m_err;
   int   gp;

   r5_stage_ctrl_if #(.IDX_W(IDX_W), .TW_AW(TW_AW)) bus();

   r5_stage_ctrl #(.D(D), .LAT(LAT), .IDX_W(IDX_W), .TW_AW(TW_AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input int sc, input int cyc, input int sel, input int exp);
      vec_t v;
      v.sc = sc; v.cyc = cyc; v.sel = sel; v.exp = exp;
      vecs.push_back(v);
   endtask

   function automatic string sel_name(input int sel);
      case (sel)
         F_BL:    return "buf_load";
         F_BF:    return "bf_fire";
         F_OV:    return "out_valid";
         F_OS:    return "out_sof";
         F_OE:    return "out_eof";
         F_TW:    return "tw_addr";
         F_BUSY:  return "busy";
         F_ERR:   return "sync_err";
         F_OPH:   return "out_ph";
         F_OIDX:  return "out_idx";
         F_PH:    return "ph";
         default: return "idx";
      endcase
   endfunction

   function automatic int get_field(input int sel);
      case (sel)
         F_BL:    return int'(bus.buf_load);
         F_BF:    return int'(bus.bf_fire);
         F_OV:    return int'(bus.out_valid);
         F_OS:    return int'(bus.out_sof);
         F_OE:    return int'(bus.out_eof);
         F_TW:    return int'(bus.tw_addr);
         F_BUSY:  return int'(bus.busy);
         F_ERR:   return int'(bus.sync_err);
         F_OPH:   return int'(bus.out_ph);
         F_OIDX:  return int'(bus.out_idx);
         F_PH:    return int'(bus.ph);
         default: return int'(bus.idx);
      endcase
   endfunction

   task automatic stim(input int sc, input int e, output bit rst, output bit v, output bit s);
      rst = (e >= 0);
      v   = 1'b0;
      s   = 1'b0;
      case (sc)
         0: begin v = (e >= 0 && e <= 84);  s = (e == 0); end
         1: begin v = (e >= 0 && e <= 169); s = (e == 0 || e == 85); end
         2: begin v = (e >= 0 && e <= 39);  s = (e == 0); end
         3: begin v = (e >= 0 && e <= 154); s = (e == 0 || e == 70); end
         4: begin v = (e >= 0 && e <= 84);  s = (e == 0); rst = (e >= 0) && (e != 100); end
         default: begin
            if (e < 0) begin
               gp = -1;
            end else if (gp < 0) begin
               v = 1'($urandom_range(0, 1));
               s = v & 1'($urandom_range(0, 1));
               if (v && s) gp = 1;
            end else begin
               int r;
               r = int'($urandom_range(0, 999));
               v = 1'b1;
               s = (gp == 0);
               if (r < 5) v = 1'b0;
               else if (r < 10) s = 1'b1;
               if (gp == FL - 1) gp = ($urandom_range(0, 1) == 1) ? 0 : -1;
               else gp = gp + 1;
            end
         end
      endcase
   endtask

   task automatic model_step(input bit rst, input bit v, input bit s, input int e);
      bit cancel;
      cancel = 1'b0;
      m_err  = 1'b0;
      if (!rst) begin
         m_pos = -1; m_arm_at = -1; m_opos = -1;
         return;
      end
      if (m_pos < 0) begin
         if (v && s) m_pos = 0;
      end else if (m_pos == FL - 1) begin
         if (v && s) m_pos = 0;
         else begin m_pos = -1; m_err = v; end
      end else if (!v) begin
         m_pos = -1; m_err = 1'b1; cancel = 1'b1;
      end else if (s) begin
         m_pos = 0; m_err = 1'b1; cancel = 1'b1;
      end else begin
         m_pos = m_pos + 1;
         if (m_pos == 4 * D) m_arm_at = e + LAT;
      end
      if (cancel) m_arm_at = -1;
      if (m_arm_at == e) begin
         m_arm_at = -1;
         m_opos   = 0;
      end else if (m_opos >= 0) begin
         m_opos = (m_opos == FL - 1) ? -1 : m_opos + 1;
      end
   endtask

   function automatic logic [29:0] model_vec();
      int ph, ix, oph, oix;
      ph  = (m_pos < 0) ? 0 : m_pos / D;
      ix  = (m_pos < 0) ? 0 : m_pos % D;
      oph = (m_opos < 0) ? 0 : m_opos / D;
      oix = (m_opos < 0) ? 0 : m_opos % D;
      return {m_pos >= 0 && m_pos < 4 * D, m_pos >= 4 * D, m_err,
              m_pos >= 0 || m_arm_at >= 0 || m_opos >= 0,
              m_opos >= 0, m_opos == 0, m_opos == FL - 1,
              3'(ph), 5'(ix), 3'(oph), 5'(oix), 7'(oph * oix)};
   endfunction

   function automatic logic [29:0] dut_vec();
      return {bus.buf_load, bus.bf_fire, bus.sync_err, bus.busy, bus.out_valid,
              bus.out_sof, bus.out_eof, bus.ph, bus.idx, bus.out_ph, bus.out_idx, bus.tw_addr};
   endfunction

   task automatic run_scenario(input int sc, input int n_edges, input int exp_vld, input int exp_err);
      int vld_cnt, err_cnt;
      bit rst, v, s;
      logic [29:0] act, exp;
      vld_cnt = 0;
      err_cnt = 0;
      for (int e = -2; e < n_edges; e++) begin
         stim(sc, e, rst, v, s);
         rst_n        = rst;
         bus.in_valid = v;
         bus.in_sof   = s;
         @(posedge clk);
         #1;
         model_step(rst, v, s, e);
         act = dut_vec();
         exp = model_vec();
         n_checks++;
         if (act !== exp) begin
            n_fail++;
            $display("FAIL model sc=%0d edge=%0d got=%h want=%h", sc, e, act, exp);
         end
         if (e >= 0) begin
            vld_cnt += int'(bus.out_valid);
            err_cnt += int'(bus.sync_err);
         end
         foreach (vecs[k]) begin
            if (vecs[k].sc == sc && vecs[k].cyc == e) begin
               n_checks++;
               if (get_field(vecs[k].sel) != vecs[k].exp) begin
                  n_fail++;
                  $display("FAIL %s sc=%0d edge=%0d got=%0d want=%0d", sel_name(vecs[k].sel),
                           sc, e, get_field(vecs[k].sel), vecs[k].exp);
               end
            end
         end
         @(negedge clk);
      end
      if (exp_vld >= 0) begin
         n_checks++;
         if (vld_cnt != exp_vld) begin
            n_fail++;
            $display("FAIL out_valid_cycles sc=%0d got=%0d want=%0d", sc, vld_cnt, exp_vld);
         end
         n_checks++;
         if (err_cnt != exp_err) begin
            n_fail++;
            $display("FAIL sync_err_pulses sc=%0d got=%0d want=%0d", sc, err_cnt, exp_err);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      gp       = -1;
      m_pos = -1; m_arm_at = -1; m_opos = -1; m_err = 1'b0;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;

      // single frame
      add(0, -1, F_BUSY, 0); add(0, -1, F_OV, 0);   add(0, -1, F_BL, 0);  add(0, -1, F_TW, 0);
      add(0, 0, F_BL, 1);    add(0, 67, F_BL, 1);   add(0, 68, F_BL, 0);
      add(0, 67, F_BF, 0);   add(0, 68, F_BF, 1);   add(0, 84, F_BF, 1);  add(0, 85, F_BF, 0);
      add(0, 84, F_OV, 0);   add(0, 85, F_OV, 1);   add(0, 85, F_OS, 1);
      add(0, 169, F_OE, 1);  add(0, 169, F_OV, 1);  add(0, 170, F_OV, 0);
      add(0, 169, F_BUSY, 1); add(0, 170, F_BUSY, 0);
      add(0, 124, F_OPH, 2); add(0, 124, F_OIDX, 5); add(0, 124, F_TW, 10);
      add(0, 169, F_TW, 64); add(0, 90, F_TW, 0);
      // back-to-back frames
      add(1, 169, F_OE, 1);  add(1, 170, F_OS, 1);  add(1, 170, F_OV, 1);
      add(1, 254, F_OE, 1);  add(1, 255, F_OV, 0);  add(1, 170, F_ERR, 0);
      // in_valid dropped mid-frame
      add(2, 39, F_ERR, 0);  add(2, 40, F_ERR, 1);  add(2, 41, F_ERR, 0);
      add(2, 39, F_BL, 1);   add(2, 40, F_BL, 0);   add(2, 40, F_BUSY, 0);
      // spurious sof in phase 4
      add(3, 69, F_BF, 1);   add(3, 70, F_ERR, 1);  add(3, 70, F_BL, 1);  add(3, 70, F_PH, 0);
      add(3, 85, F_OV, 0);   add(3, 137, F_BF, 0);  add(3, 138, F_BF, 1);
      add(3, 154, F_OV, 0);  add(3, 155, F_OV, 1);  add(3, 155, F_OS, 1);
      // reset during an output run
      add(4, 99, F_OV, 1);   add(4, 99, F_OIDX, 14); add(4, 100, F_OV, 0); add(4, 100, F_BUSY, 0);
      add(4, 100, F_OIDX, 0); add(4, 100, F_TW, 0); add(4, 150, F_OV, 0);

      @(negedge clk);
      run_scenario(0, 200, 85, 0);
      run_scenario(1, 280, 170, 0);
      run_scenario(2, 120, 0, 1);
      run_scenario(3, 260, 85, 1);
      run_scenario(4, 200, 15, 0);
      run_scenario(5, 3000, -1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
